// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM-stage access unit and the EX/MEM control encoding.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the 2-bit Mem control field carried by EX/MEM.
  localparam int MEM_RD_BIT = 1;
  localparam int MEM_WR_BIT = 0;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous write, registered read, asynchronous clear.
module dmem_array #(
  parameter int WORDS = 128,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[idx] <= wdata;
      end
      if (re) begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_stage_unit.sv
// MEM-stage load/store unit: fixed-latency access to the data array with pipeline stall.
//  state | meaning
//  IDLE  | examine EX/MEM request; aligned request starts an access
//  BUSY  | access in flight, cnt counts down to the commit cycle
//  DONE  | access finished, rdata_o valid for MEM/WB, pipeline advances
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int MEM_WORDS = 128,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  Mem_i,
  input  logic [31:0] alu_ans_i,
  input  logic [31:0] rtdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   cap_idx;
  logic [31:0]        cap_wdata;
  logic               cap_wr;
  logic               cap_rd;

  logic               req;
  logic               aligned;
  logic               start;
  logic               fire;
  logic               arr_we;
  logic               arr_re;
  logic               unused_addr_bits;

  assign req     = |Mem_i;
  assign aligned = (alu_ans_i[1:0] == 2'b00);
  assign start   = (state == IDLE) && req && aligned;
  assign fire    = (state == BUSY) && (cnt == '0);

  // Write wins when both control bits are set, so the read port stays quiet.
  assign arr_we = fire && cap_wr;
  assign arr_re = fire && cap_rd && !cap_wr;

  assign unused_addr_bits = ^{alu_ans_i[31:IDX_W+2]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      cap_rd    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= BUSY;
            cnt       <= CNT_W'(LATENCY - 1);
            cap_idx   <= alu_ans_i[IDX_W+1:2];
            cap_wdata <= rtdata_i;
            cap_wr    <= Mem_i[MEM_WR_BIT];
            cap_rd    <= Mem_i[MEM_RD_BIT];
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (cap_idx),
    .wdata (cap_wdata),
    .rdata (rdata_o)
  );

  // Gated by reset so a request sitting on EX/MEM during reset cannot stall or flag.
  assign stall_o    = rst_i && (start || (state == BUSY));
  assign misalign_o = rst_i && (state == IDLE) && req && !aligned;
  assign done_o     = (state == DONE);

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed table, hand sequences, random vs. model.
module tb_mem_stage_unit;

  localparam int MEM_WORDS = 128;
  localparam int LATENCY   = 2;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  Mem_i;
  logic [31:0] alu_ans_i;
  logic [31:0] rtdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] ref_rdata;

  typedef struct {
    logic [1:0]  mem;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  mem_stage_unit #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .Mem_i      (Mem_i),
    .alu_ans_i  (alu_ans_i),
    .rtdata_i   (rtdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .misalign_o (misalign_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    ref_rdata = '0;
  endtask

  // Entered just after a rising edge with the unit in IDLE; leaves it the same way.
  task automatic do_access(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                           input bit scramble);
    int n;
    Mem_i = m; alu_ans_i = a; rtdata_i = d;
    if (m == 2'b00) begin
      @(negedge clk_i);
      chk("idle_stall", 32'(stall_o), 32'd0);
      chk("idle_done", 32'(done_o), 32'd0);
      chk("idle_misalign", 32'(misalign_o), 32'd0);
      @(posedge clk_i); #1;
    end else if (a[1:0] != 2'b00) begin
      @(negedge clk_i);
      chk("misalign_flag", 32'(misalign_o), 32'd1);
      chk("misalign_stall", 32'(stall_o), 32'd0);
      @(posedge clk_i); #1;
      Mem_i = 2'b00;
      @(negedge clk_i);
      chk("misalign_rdata", rdata_o, ref_rdata);
      chk("misalign_no_done", 32'(done_o), 32'd0);
      @(posedge clk_i); #1;
    end else begin
      n = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk_i);
        if (!stall_o) break;
        n++;
        chk("busy_no_done", 32'(done_o), 32'd0);
        @(posedge clk_i); #1;
        if (scramble && n == 1) begin
          alu_ans_i = a ^ 32'h4;
          rtdata_i  = ~d;
          Mem_i     = 2'b10;
        end
      end
      chk("stall_len", 32'(n), 32'(LATENCY + 1));
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("done_misalign", 32'(misalign_o), 32'd0);
      if (m[0]) ref_mem[word_of(a)] = d;
      else ref_rdata = ref_mem[word_of(a)];
      Mem_i = 2'b00;
      chk("rdata", rdata_o, ref_rdata);
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    tbl[0] = '{2'b00, 32'h0000_0000, 32'h0,         32'h0};
    tbl[1] = '{2'b01, 32'h0000_0010, 32'hDEADBEEF,  32'h0};
    tbl[2] = '{2'b10, 32'h0000_0014, 32'h0,         32'h0};
    tbl[3] = '{2'b10, 32'h0000_0010, 32'h0,         32'hDEADBEEF};
    tbl[4] = '{2'b10, 32'h0000_0013, 32'h0,         32'hDEADBEEF};
    tbl[5] = '{2'b01, 32'h0000_0200, 32'h1,         32'hDEADBEEF};
    tbl[6] = '{2'b10, 32'h0000_0000, 32'h0,         32'h1};
    tbl[7] = '{2'b11, 32'h0000_0008, 32'h5,         32'h1};
    tbl[8] = '{2'b10, 32'h0000_0008, 32'h0,         32'h5};

    rst_i = 1'b0; Mem_i = 2'b10; alu_ans_i = 32'h10; rtdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    Mem_i = 2'b00;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 9; i++) begin
      do_access(tbl[i].mem, tbl[i].addr, tbl[i].data, 1'b0);
      chk($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].exp_rdata);
    end

    // Inputs changed during BUSY must not affect the captured write.
    do_access(2'b01, 32'h0000_0020, 32'h1234_5678, 1'b1);
    do_access(2'b10, 32'h0000_0020, 32'h0, 1'b0);
    chk("scramble_orig", rdata_o, 32'h1234_5678);
    do_access(2'b10, 32'h0000_0024, 32'h0, 1'b0);
    chk("scramble_other", rdata_o, 32'h0);

    // Reset in the second BUSY cycle of a write: nothing may commit.
    Mem_i = 2'b01; alu_ans_i = 32'h4; rtdata_i = 32'hA5;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_rdata", rdata_o, 32'd0);
    model_reset();
    Mem_i = 2'b00;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    do_access(2'b00, 32'h0, 32'h0, 1'b0);
    do_access(2'b10, 32'h0000_0004, 32'h0, 1'b0);
    chk("midrst_read", rdata_o, 32'd0);
    do_access(2'b10, 32'h0000_0010, 32'h0, 1'b0);
    chk("midrst_cleared", rdata_o, 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [1:0]  m;
      logic [31:0] a;
      m = 2'($urandom_range(0, 3));
      a = ($urandom() & 32'hFFFF_FE00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      do_access(m, a, $urandom(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
